// File: rtl/cpu_wb_pkg.sv
// Shared types and helpers for the writeback arbiter and its per-channel FIFOs.
package cpu_wb_pkg;

    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_REG_W = 5;

    typedef struct packed {
        logic [DEF_REG_W-1:0] rd;
        logic [DEF_XLEN-1:0]  data;
    } wb_entry_t;

    // Round-robin successor of the last granted channel.
    function automatic int unsigned rr_next(input int unsigned last, input int unsigned num_ch);
        return (last + 1 >= num_ch) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// Per-channel result FIFO; exposes its contents oldest-first for the forwarding search.
module cpu_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 37
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [W-1:0]                 head,
    output logic [DEPTH*W-1:0]           entries
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Slot i of entries is the i-th oldest entry; slots at or beyond count are stale.
    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*W +: W] = mem_q[AW'((32'(rd_ptr_q) + 32'(i)) % DEPTH)];
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cpu_writeback_arbiter.sv
// Merges NUM_CH buffered result channels onto NUM_WPORTS register-bank write ports with
// round-robin grants, and answers forwarding queries against all pending entries.
module cpu_writeback_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned NUM_WPORTS = 1,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned REG_W      = DEF_REG_W,
    parameter int unsigned NUM_Q      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH*REG_W-1:0]     in_rd,
    input  logic [NUM_CH*XLEN-1:0]      in_data,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [NUM_WPORTS-1:0]       wr_en,
    output logic [NUM_WPORTS*REG_W-1:0] wr_reg,
    output logic [NUM_WPORTS*XLEN-1:0]  wr_data,
    input  logic [NUM_Q*REG_W-1:0]      q_reg,
    output logic [NUM_Q-1:0]            q_hit,
    output logic [NUM_Q*XLEN-1:0]       q_data,
    output logic                        idle
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned EW = REG_W + XLEN;

    logic [CW-1:0]     count [NUM_CH];
    logic [EW-1:0]     head  [NUM_CH];
    logic [EW-1:0]     ent   [NUM_CH][BUF_DEPTH];
    logic [NUM_CH-1:0] push, pop;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

    int unsigned arb_k, arb_ch, arb_last;
    logic        arb_any;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BUF_DEPTH*EW-1:0] ent_flat;

        assign in_ready[c] = count[c] < CW'(BUF_DEPTH);
        // r0 writes complete the handshake but are never buffered.
        assign push[c] = in_valid[c] & in_ready[c] & (in_rd[c*REG_W +: REG_W] != '0);

        cpu_wb_fifo #(
            .DEPTH (BUF_DEPTH),
            .W     (EW)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[c]),
            .pop       (pop[c]),
            .push_data ({in_rd[c*REG_W +: REG_W], in_data[c*XLEN +: XLEN]}),
            .count     (count[c]),
            .head      (head[c]),
            .entries   (ent_flat)
        );

        for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_ent
            assign ent[c][i] = ent_flat[i*EW +: EW];
        end
    end

    always_comb begin
        wr_en    = '0;
        wr_reg   = '0;
        wr_data  = '0;
        pop      = '0;
        arb_k    = 0;
        arb_ch   = 0;
        arb_last = 0;
        arb_any  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_ch = (32'(rr_ptr_q) + 32'(i)) % NUM_CH;
            if (count[arb_ch] != '0 && arb_k < NUM_WPORTS) begin
                pop[arb_ch]                    = 1'b1;
                wr_en[arb_k]                   = 1'b1;
                wr_reg[arb_k*REG_W +: REG_W]   = head[arb_ch][EW-1:XLEN];
                wr_data[arb_k*XLEN +: XLEN]    = head[arb_ch][XLEN-1:0];
                arb_k++;
                arb_last = arb_ch;
                arb_any  = 1'b1;
            end
        end
        rr_ptr_d = arb_any ? PW'(rr_next(arb_last, NUM_CH)) : rr_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Channels scanned high to low and entries oldest to newest, so the surviving match is
    // the newest entry of the lowest matching channel. Heads being written still count.
    always_comb begin
        q_hit  = '0;
        q_data = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (q_reg[q*REG_W +: REG_W] != '0) begin
                for (int c = NUM_CH - 1; c >= 0; c--) begin
                    for (int i = 0; i < BUF_DEPTH; i++) begin
                        if (CW'(i) < count[c] &&
                            ent[c][i][EW-1:XLEN] == q_reg[q*REG_W +: REG_W]) begin
                            q_hit[q]                 = 1'b1;
                            q_data[q*XLEN +: XLEN]   = ent[c][i][XLEN-1:0];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        idle = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (count[c] != '0) begin
                idle = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Self-checking bench: single-port arbiter with a write scoreboard, plus a dual-port instance.
module tb_cpu_writeback_arbiter;
    import cpu_wb_pkg::*;

    localparam int unsigned NCH = 3;
    localparam int unsigned XL  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned NQ  = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [NCH-1:0]    in_valid, in_ready;
    logic [NCH*RW-1:0] in_rd;
    logic [NCH*XL-1:0] in_data;
    logic [0:0]        wr_en;
    logic [RW-1:0]     wr_reg;
    logic [XL-1:0]     wr_data;
    logic [NQ*RW-1:0]  q_reg;
    logic [NQ-1:0]     q_hit;
    logic [NQ*XL-1:0]  q_data;
    logic              idle;

    logic [NCH-1:0]    in_valid2, in_ready2;
    logic [NCH*RW-1:0] in_rd2;
    logic [NCH*XL-1:0] in_data2;
    logic [1:0]        wr_en2;
    logic [2*RW-1:0]   wr_reg2;
    logic [2*XL-1:0]   wr_data2;
    logic [NQ*RW-1:0]  q_reg2;
    logic [NQ-1:0]     q_hit2;
    logic [NQ*XL-1:0]  q_data2;
    logic              idle2;

    cpu_writeback_arbiter #(
        .NUM_CH(NCH), .NUM_WPORTS(1), .BUF_DEPTH(2), .XLEN(XL), .REG_W(RW), .NUM_Q(NQ)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_rd(in_rd), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .q_reg(q_reg), .q_hit(q_hit), .q_data(q_data), .idle(idle)
    );

    cpu_writeback_arbiter #(
        .NUM_CH(NCH), .NUM_WPORTS(2), .BUF_DEPTH(2), .XLEN(XL), .REG_W(RW), .NUM_Q(NQ)
    ) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid2), .in_rd(in_rd2),
        .in_data(in_data2), .in_ready(in_ready2), .wr_en(wr_en2), .wr_reg(wr_reg2),
        .wr_data(wr_data2), .q_reg(q_reg2), .q_hit(q_hit2), .q_data(q_data2), .idle(idle2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: per-channel queues of accepted, non-r0 writes in arrival order.
    wb_entry_t exp_q [NCH][$];
    bit        sb_found;

    always @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) exp_q[c].delete();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (in_valid[c] && in_ready[c] && in_rd[c*RW +: RW] != 0) begin
                    exp_q[c].push_back(wb_entry_t'{rd: in_rd[c*RW +: RW],
                                                   data: in_data[c*XL +: XL]});
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && wr_en[0]) begin
            sb_found = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (!sb_found && exp_q[c].size() > 0 && exp_q[c][0].rd == wr_reg &&
                    exp_q[c][0].data == wr_data) begin
                    sb_found = 1'b1;
                    void'(exp_q[c].pop_front());
                end
            end
            n_cmp++;
            if (!sb_found) begin
                n_bad++;
                $display("FAIL sb_write: got r%0d=0x%0h, required an oldest pending entry",
                         wr_reg, wr_data);
            end
        end
    end

    task automatic idle_inputs();
        in_valid = '0;
        in_rd    = '0;
        in_data  = '0;
    endtask

    task automatic set_ch(input int c, input logic [RW-1:0] rd, input logic [XL-1:0] d);
        in_valid[c]        = 1'b1;
        in_rd[c*RW +: RW]  = rd;
        in_data[c*XL +: XL] = d;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        int            ch;
        logic [RW-1:0] rd;
        logic [XL-1:0] data;
    } vec_t;

    vec_t vecs [5];
    bit   exp_w;
    int   n0, n1;
    bit   a0, a1, chk_ready1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 5'd4,  32'hDEAD_BEEF};
        vecs[1] = '{0, 5'd9,  32'h1234_5678};
        vecs[2] = '{2, 5'd31, 32'hFFFF_FFFF};
        vecs[3] = '{1, 5'd0,  32'h0000_AAAA};
        vecs[4] = '{2, 5'd1,  32'h0000_0001};

        reset = 1'b1;
        idle_inputs();
        in_valid2 = '0; in_rd2 = '0; in_data2 = '0; q_reg2 = '0;
        q_reg = '0;
        step();
        step();

        // Reset held while every channel offers data: nothing may be stored.
        reset = 1'b1;
        set_ch(0, 5'd1, 32'h1);
        set_ch(1, 5'd2, 32'h2);
        set_ch(2, 5'd3, 32'h3);
        q_reg = {5'd2, 5'd1};
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", in_ready, 3'b111);
        chk("rst_q_hit", q_hit, 0);
        chk("rst_wr_reg", wr_reg, 0);

        // Single-transaction vectors: write next cycle, forwarding sees the head, then idle.
        for (int v = 0; v < 5; v++) begin
            exp_w = (vecs[v].rd != 0);
            idle_inputs();
            set_ch(vecs[v].ch, vecs[v].rd, vecs[v].data);
            q_reg = {5'd0, vecs[v].rd};
            step();
            idle_inputs();
            @(negedge clock);
            chk("vec_wr_en", wr_en, exp_w);
            chk("vec_wr_reg", wr_reg, exp_w ? vecs[v].rd : 5'd0);
            chk("vec_wr_data", wr_data, exp_w ? vecs[v].data : 32'd0);
            chk("vec_q_hit", q_hit, {1'b0, exp_w});
            chk("vec_q_data", q_data[XL-1:0], exp_w ? vecs[v].data : 32'd0);
            step();
            @(negedge clock);
            chk("vec_idle", idle, 1);
            chk("vec_q_hit_after", q_hit, 0);
        end

        // Contention: three channels at once, one port, rr starts at 0.
        q_reg = '0;
        do_reset();
        set_ch(0, 5'd1, 32'h100);
        set_ch(1, 5'd2, 32'h200);
        set_ch(2, 5'd3, 32'h300);
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("cont_wr_en", wr_en, 1);
            chk("cont_wr_reg", wr_reg, k + 1);
            step();
        end
        // rr_ptr is back at 0, so ch0 must beat ch2.
        set_ch(2, 5'd9, 32'h900);
        set_ch(0, 5'd8, 32'h800);
        step();
        idle_inputs();
        @(negedge clock);
        chk("rr_first", wr_reg, 8);
        step();
        @(negedge clock);
        chk("rr_second", wr_reg, 9);
        step();
        @(negedge clock);
        chk("rr_idle", idle, 1);

        // Backpressure: ch0 streams continuously, ch1 pushes three entries into depth 2.
        do_reset();
        n0 = 0; n1 = 0; chk_ready1 = 1'b0;
        for (int cyc = 0; cyc < 40 && !(n0 == 6 && n1 == 3); cyc++) begin
            idle_inputs();
            if (n0 < 6) set_ch(0, 5'd10, 32'hA000 + n0);
            if (n1 < 3) set_ch(1, 5'd11, 32'hB000 + n1);
            @(negedge clock);
            if (chk_ready1) begin
                chk("bp_ready1_low", in_ready[1], 0);
                chk_ready1 = 1'b0;
            end
            a0 = in_valid[0] & in_ready[0];
            a1 = in_valid[1] & in_ready[1];
            step();
            if (a0) n0++;
            if (a1) begin
                n1++;
                if (n1 == 2) chk_ready1 = 1'b1;
            end
        end
        idle_inputs();
        chk("bp_ch0_sent", n0, 6);
        chk("bp_ch1_sent", n1, 3);
        for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (idle) break;
        end
        chk("bp_drained", idle, 1);
        chk("bp_sb_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

        // Forwarding: ch2 holds two pending r7 values; newest must be returned.
        do_reset();
        set_ch(0, 5'd12, 32'hC0);
        set_ch(1, 5'd13, 32'hD0);
        set_ch(2, 5'd7, 32'h11);
        q_reg = {5'd13, 5'd7};
        step();
        idle_inputs();
        set_ch(2, 5'd7, 32'h22);
        step();
        idle_inputs();
        @(negedge clock);
        chk("fwd_hit", q_hit, 2'b11);
        chk("fwd_data0", q_data[XL-1:0], 32'h22);
        chk("fwd_data1", q_data[2*XL-1:XL], 32'hD0);
        chk("fwd_wr_reg", wr_reg, 13);
        step();
        @(negedge clock);
        chk("fwd_wr_old", wr_data, 32'h11);
        chk("fwd_hit_mid", q_hit, 2'b01);
        chk("fwd_data_mid", q_data[XL-1:0], 32'h22);
        step();
        @(negedge clock);
        chk("fwd_wr_new", wr_data, 32'h22);
        chk("fwd_data_last", q_data[XL-1:0], 32'h22);
        step();
        @(negedge clock);
        chk("fwd_hit_gone", q_hit, 0);
        q_reg = '0;

        // Reset mid-operation drops pending writes.
        set_ch(0, 5'd3, 32'h33);
        set_ch(1, 5'd4, 32'h44);
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_idle", idle, 1);

        // Dual port: r0 accepted and dropped, r5/r6 written together.
        do_reset();
        in_valid2 = 3'b111;
        in_rd2    = {5'd6, 5'd5, 5'd0};
        in_data2  = {32'h66, 32'h55, 32'h0F};
        @(negedge clock);
        chk("dp_ready", in_ready2, 3'b111);
        step();
        in_valid2 = '0;
        @(negedge clock);
        chk("dp_wr_en", wr_en2, 2'b11);
        chk("dp_reg0", wr_reg2[RW-1:0], 5);
        chk("dp_reg1", wr_reg2[2*RW-1:RW], 6);
        chk("dp_data0", wr_data2[XL-1:0], 32'h55);
        chk("dp_data1", wr_data2[2*XL-1:XL], 32'h66);
        step();
        @(negedge clock);
        chk("dp_wr_en_after", wr_en2, 0);
        chk("dp_idle", idle2, 1);

        chk("sb_final_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_writeback_arbiter.md
Name: cpu_writeback_arbiter

Overview:
- Parametrised writeback stage that merges NUM_CH independent result channels (ALU, MEM, MUL, ...) onto NUM_WPORTS register-bank write ports.
- Each channel has a small FIFO that absorbs write-port conflicts.
- Grants are round-robin. A lookup port lets the forwarding unit read pending, not-yet-written values.
- Sits between the last execute/memory stages and the register bank; replaces the fixed ALU+MUL two-path writeback.

Parameters:
- NUM_CH, 3, number of result channels (1..8)
- NUM_WPORTS, 1, register-bank write ports (1..NUM_CH)
- BUF_DEPTH, 2, entries per channel FIFO (power of two, >=1)
- XLEN, 32, data width
- REG_W, 5, register index width
- NUM_Q, 2, forwarding lookup ports

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_CH  channel c presents a result
- in_rd  in  NUM_CH*REG_W  destination register per channel
- in_data  in  NUM_CH*XLEN  result data per channel
- in_ready  out  NUM_CH  channel c can accept this cycle
- wr_en  out  NUM_WPORTS  write-port enable to register bank
- wr_reg  out  NUM_WPORTS*REG_W  write-port register index
- wr_data  out  NUM_WPORTS*XLEN  write-port data
- q_reg  in  NUM_Q*REG_W  forwarding query register
- q_hit  out  NUM_Q  a pending write to q_reg exists
- q_data  out  NUM_Q*XLEN  newest pending value for q_reg
- idle  out  1  all FIFOs empty

Behaviour:
- Clocking and reset: one clock, rising edge; reset is synchronous and active-high. Reset empties all FIFOs and sets the round-robin pointer to 0.
- Outputs after reset: wr_en=0, q_hit=0, idle=1, in_ready all 1. wr_reg, wr_data and q_data drive 0 whenever the matching enable/hit is 0.
- Accept rule: a channel transfer occurs when in_valid&in_ready at a rising edge.
- in_ready[c] = (count[c] < BUF_DEPTH). It depends only on the registered count; there is no same-cycle pop credit.
- Writes to r0: a transfer with in_rd==0 is accepted (ready rules unchanged) and discarded; it is never stored.
- Latency: a value accepted at edge t appears as a FIFO head in cycle t+1. It is written at the end of the first cycle in which it is granted. Minimum latency to the bank is 1 cycle.
- Arbitration (combinational, per cycle): among non-empty channels, grant up to NUM_WPORTS heads.
  - Scan order starts at channel rr_ptr and wraps modulo NUM_CH.
  - The k-th granted channel drives write port k; ungranted ports drive wr_en=0.
  - A granted head is popped at the edge.
- Round-robin update: if any grant, rr_ptr <= (last granted channel + 1) mod NUM_CH; otherwise rr_ptr holds.
- Simultaneous events: push and pop on the same channel in one cycle is legal. The count is unchanged and the new entry goes behind the remaining ones.
- Ordering guarantees:
  - Within a channel, writes reach the bank in FIFO order.
  - Across channels there is no ordering guarantee. Issue logic guarantees no two channels hold writes to the same rd simultaneously.
- Forwarding lookup (combinational): search every valid FIFO entry, including heads being written this cycle.
  - q_hit=1 if any entry matches q_reg.
  - q_data = the newest matching entry within a channel. If several channels match, the lowest channel index wins.
  - q_reg==0 gives q_hit=0.
- Bank interaction: an entry leaves the FIFO on the same edge the bank captures it, so a value is always visible either to the lookup or in the bank. There is no gap.
- idle = all counts zero.
- Reset mid-operation: all pending writes are dropped. wr_en=0 in the cycle after the reset edge.
- Counts: width $clog2(BUF_DEPTH+1). Pointers wrap modulo BUF_DEPTH.

Decomposition:
- Shared package cpu_wb_pkg:
  - wb_entry_t struct {logic [REG_W-1:0] rd; logic [XLEN-1:0] data;}
  - defaults for XLEN and REG_W
  - function rr_next()
- Sub-module cpu_wb_fifo (per channel, generated NUM_CH times):
  - synchronous reset; push/pop; count; head output
  - flat entry-array output for the lookup search
- The top level holds the arbiter, rr_ptr and the lookup muxes.

Test Plan:
- Reset: assert reset with all channels valid -> next cycle wr_en=0, idle=1, in_ready=3'b111, and no entry is stored.
- Single channel: NUM_WPORTS=1; ch1 sends rd=4 data=0xDEAD_BEEF at edge t -> cycle t+1 has wr_en=1, wr_reg=4, wr_data=0xDEADBEEF; cycle t+2 has idle=1.
- Contention: ch0, ch1 and ch2 each push one entry (rd=1,2,3) at the same edge with rr_ptr=0 and one write port -> writes to r1, r2, r3 on three consecutive cycles; rr_ptr ends at 0.
- Backpressure: stall grants by holding ch0 busy with continuous ch0 traffic, then push 3 entries into ch1 with BUF_DEPTH=2 -> in_ready[1]=0 after the second accept; the third value is held by the source and accepted later; no data loss; order preserved.
- Forwarding: ch2 FIFO holds rd=7 values 0x11 then 0x22 (both pending); q_reg=7 -> q_hit=1, q_data=0x22. After both are written -> q_hit=0.
- r0 discard and dual port: NUM_WPORTS=2; ch0 sends rd=0 while ch1 and ch2 send rd=5 and rd=6 -> ch0 is accepted but never written; r5 and r6 are written in the same cycle on ports 0 and 1.
